// File: rtl/reg_writeback_arbiter.sv
// Write-back arbiter feeding the register file: ALU/load results win, long-latency
// results are queued in a small FIFO and drained whenever the ALU port is idle.
module reg_writeback_arbiter #(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned AW           = 5,
  parameter int unsigned DEPTH        = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   alu_wr_en,
  input  logic [AW-1:0]          alu_wr_addr,
  input  logic [XLEN-1:0]        alu_wr_data,
  input  logic                   lu_valid,
  output logic                   lu_ready,
  input  logic [AW-1:0]          lu_addr,
  input  logic [XLEN-1:0]        lu_data,
  output logic                   regWrite,
  output logic [AW-1:0]          writeReg,
  output logic [XLEN-1:0]        writeData,
  output logic                   stall,
  output logic [$clog2(DEPTH):0] fifo_count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

  typedef struct packed {
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data;
  } wbEntry_t;

  wbEntry_t        mem [DEPTH];
  logic [PW-1:0]   rdPtrQ, wrPtrQ;
  logic [CW-1:0]   countQ, countNext;
  logic [SW-1:0]   starveQ, starveNext;
  logic            luReadyQ, luReadyNext;
  logic            stallQ, stallNext;
  logic            regWriteQ, regWriteNext;
  logic [AW-1:0]   writeRegQ;
  logic [XLEN-1:0] writeDataQ;

  logic            fifoEmpty;
  logic            push;
  logic            pop;
  logic            selValid;
  wbEntry_t        selEntry;

  // Selection, occupancy and starvation bookkeeping for the coming edge
  always_comb begin
    fifoEmpty    = (countQ == '0);
    push         = lu_valid && luReadyQ;
    pop          = !alu_wr_en && !fifoEmpty;
    selValid     = alu_wr_en || pop;
    selEntry     = mem[rdPtrQ];
    starveNext   = starveQ;

    if (alu_wr_en) begin
      selEntry.addr = alu_wr_addr;
      selEntry.data = alu_wr_data;
    end

    countNext = countQ + CW'(push) - CW'(pop);

    if (pop || fifoEmpty) begin
      starveNext = '0;
    end else if (alu_wr_en && (starveQ != SW'(STARVE_LIMIT))) begin
      starveNext = starveQ + SW'(1);
    end

    // x0 is hard-wired zero: the entry is consumed but never written
    regWriteNext = selValid && (selEntry.addr != '0);
    stallNext    = (starveNext == SW'(STARVE_LIMIT)) || (countNext == CW'(DEPTH));
    luReadyNext  = (countNext < CW'(DEPTH));
  end

  // FIFO storage carries no reset; validity lives in the pointers and count
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wrPtrQ] <= wbEntry_t'{addr: lu_addr, data: lu_data};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdPtrQ     <= '0;
      wrPtrQ     <= '0;
      countQ     <= '0;
      starveQ    <= '0;
      luReadyQ   <= 1'b0;
      stallQ     <= 1'b0;
      regWriteQ  <= 1'b0;
      writeRegQ  <= '0;
      writeDataQ <= '0;
    end else begin
      if (push) begin
        wrPtrQ <= wrPtrQ + PW'(1);
      end
      if (pop) begin
        rdPtrQ <= rdPtrQ + PW'(1);
      end
      countQ    <= countNext;
      starveQ   <= starveNext;
      luReadyQ  <= luReadyNext;
      stallQ    <= stallNext;
      regWriteQ <= regWriteNext;
      // Address/data hold their last written value while idle
      if (regWriteNext) begin
        writeRegQ  <= selEntry.addr;
        writeDataQ <= selEntry.data;
      end
    end
  end

  assign lu_ready   = luReadyQ;
  assign stall      = stallQ;
  assign fifo_count = countQ;
  assign regWrite   = regWriteQ;
  assign writeReg   = writeRegQ;
  assign writeData  = writeDataQ;

endmodule

// File: tb/tb_reg_writeback_arbiter.sv
// Bench for reg_writeback_arbiter: directed scenarios plus random traffic, checked
// against a queue-based reference model through a write-back scoreboard.
module tb_reg_writeback_arbiter;

  localparam int unsigned XLEN         = 32;
  localparam int unsigned AW           = 5;
  localparam int unsigned DEPTH        = 2;
  localparam int unsigned STARVE_LIMIT = 4;
  localparam int unsigned CW           = $clog2(DEPTH) + 1;

  logic            clk;
  logic            rst_n;
  logic            alu_wr_en;
  logic [AW-1:0]   alu_wr_addr;
  logic [XLEN-1:0] alu_wr_data;
  logic            lu_valid;
  logic            lu_ready;
  logic [AW-1:0]   lu_addr;
  logic [XLEN-1:0] lu_data;
  logic            regWrite;
  logic [AW-1:0]   writeReg;
  logic [XLEN-1:0] writeData;
  logic            stall;
  logic [CW-1:0]   fifo_count;

  reg_writeback_arbiter #(
    .XLEN(XLEN), .AW(AW), .DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_wr_en(alu_wr_en), .alu_wr_addr(alu_wr_addr), .alu_wr_data(alu_wr_data),
    .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_addr(lu_addr), .lu_data(lu_data),
    .regWrite(regWrite), .writeReg(writeReg), .writeData(writeData),
    .stall(stall), .fifo_count(fifo_count)
  );

  typedef struct { logic [AW-1:0] addr; logic [XLEN-1:0] data; } entT;
  typedef struct { int cyc; logic [AW-1:0] addr; logic [XLEN-1:0] data; } expT;

  entT mFifo[$];
  expT expQ[$];
  int  mStarve = 0;
  bit  mReady  = 0;
  bit  mStall  = 0;
  bit  lastRst = 1;
  bit  monOn   = 0;
  int  cyc     = 0;
  int  checks  = 0;
  int  errors  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, expv);
    end
  endfunction

  // Monitor: every cycle either a scheduled write is due or the port must be quiet
  always @(negedge clk) begin
    expT e;
    if (monOn) begin
      if (expQ.size() > 0 && expQ[0].cyc <= cyc) begin
        e = expQ.pop_front();
        chk("wb_regWrite", 64'(regWrite), 64'(1));
        chk("wb_cycle", 64'(cyc), 64'(e.cyc));
        if (regWrite === 1'b1) begin
          chk("wb_writeReg", 64'(writeReg), 64'(e.addr));
          chk("wb_writeData", 64'(writeData), 64'(e.data));
        end
      end else begin
        chk("wb_quiet", 64'(regWrite), 64'(0));
      end
    end
  end

  // One clock of stimulus; the model advances to the state expected after the edge
  task automatic step(input bit rst, input bit aEn, input logic [AW-1:0] aAddr,
                      input logic [XLEN-1:0] aData, input bit lv,
                      input logic [AW-1:0] lAddr, input logic [XLEN-1:0] lData);
    int  sz;
    bit  push;
    bit  pop;
    entT h;
    @(negedge clk);
    chk("fifo_count", 64'(fifo_count), 64'(mFifo.size()));
    chk("lu_ready", 64'(lu_ready), 64'(mReady));
    chk("stall", 64'(stall), 64'(mStall));
    if (lastRst) begin
      chk("reset_writeReg", 64'(writeReg), 64'(0));
      chk("reset_writeData", 64'(writeData), 64'(0));
    end
    lastRst     = rst;
    rst_n       = !rst;
    alu_wr_en   = aEn;
    alu_wr_addr = aAddr;
    alu_wr_data = aData;
    lu_valid    = lv;
    lu_addr     = lAddr;
    lu_data     = lData;
    if (rst) begin
      mFifo.delete();
      mStarve = 0;
      mReady  = 0;
      mStall  = 0;
      while (expQ.size() > 0 && expQ[$].cyc > cyc) void'(expQ.pop_back());
      return;
    end
    sz   = mFifo.size();
    push = lv && mReady;
    pop  = !aEn && (sz > 0);
    if (aEn) begin
      if (aAddr != 0) expQ.push_back(expT'{cyc + 1, aAddr, aData});
    end else if (pop) begin
      h = mFifo.pop_front();
      if (h.addr != 0) expQ.push_back(expT'{cyc + 1, h.addr, h.data});
    end
    if (pop || sz == 0) mStarve = 0;
    else if (aEn && mStarve < STARVE_LIMIT) mStarve++;
    if (push) mFifo.push_back(entT'{lAddr, lData});
    mReady = (mFifo.size() < DEPTH);
    mStall = (mStarve == STARVE_LIMIT) || (mFifo.size() == DEPTH);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, '0, '0, 0, '0, '0);
  endtask

  task automatic alu(input logic [AW-1:0] a, input logic [XLEN-1:0] d);
    step(0, 1, a, d, 0, '0, '0);
  endtask

  task automatic lu(input logic [AW-1:0] a, input logic [XLEN-1:0] d);
    step(0, 0, '0, '0, 1, a, d);
  endtask

  initial begin
    bit              dense;
    bit              aEn;
    bit              lv;
    logic [AW-1:0]   aAddr;
    logic [AW-1:0]   lAddr;
    rst_n       = 1'b0;
    alu_wr_en   = 1'b0;
    alu_wr_addr = '0;
    alu_wr_data = '0;
    lu_valid    = 1'b0;
    lu_addr     = '0;
    lu_data     = '0;
    monOn       = 1'b1;

    idle(2);
    // ALU passthrough
    alu(5'd5, 32'hDEADBEEF);
    idle(2);
    // x0 suppression on both paths
    alu(5'd0, 32'h0000_0123);
    idle(1);
    lu(5'd0, 32'h0000_0055);
    idle(3);
    // Drain ordering
    lu(5'd3, 32'h11);
    lu(5'd4, 32'h22);
    idle(4);
    // Full / backpressure: third offer must be refused
    step(0, 1, 5'd7, 32'hA0, 1, 5'd8,  32'hB0);
    step(0, 1, 5'd7, 32'hA1, 1, 5'd9,  32'hB1);
    step(0, 1, 5'd7, 32'hA2, 1, 5'd10, 32'hB2);
    step(0, 1, 5'd7, 32'hA3, 0, '0, '0);
    idle(4);
    // Starvation
    lu(5'd12, 32'hC0DE);
    for (int i = 0; i < 6; i++) alu(5'd20, 32'h100 + 32'(i));
    idle(3);
    // Reset with two entries queued
    step(0, 1, 5'd1, 32'h1, 1, 5'd13, 32'hE1);
    step(0, 1, 5'd2, 32'h2, 1, 5'd14, 32'hE2);
    step(1, 0, '0, '0, 0, '0, '0);
    idle(4);

    dense = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (i % 100 == 0) dense = ~dense;
      aEn   = dense ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      lv    = ($urandom_range(0, 1) == 1);
      aAddr = ($urandom_range(0, 7) == 0) ? 5'd0 : AW'($urandom_range(1, 31));
      lAddr = ($urandom_range(0, 7) == 0) ? 5'd0 : AW'($urandom_range(1, 31));
      step(($urandom_range(0, 299) == 0), aEn, aAddr, $urandom, lv, lAddr, $urandom);
    end
    idle(6);
    chk("scoreboard_drained", 64'(expQ.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
